// File: rtl/sseg_scan_mux.sv
// rtl/sseg_scan_mux.sv - time-multiplexed 7-segment scanner with dead time, shadow load and leading-zero blanking
// Optional build macro SSEG_DIM_EN adds the brightness input and a 4-bit PWM dimmer.
module sseg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int PRESCALE    = 65536,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    load,
  input  logic                    blank_lz,
`ifdef SSEG_DIM_EN
  input  logic [3:0]              brightness,
`endif
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              sseg,
  output logic                    dp,
  output logic                    slot_tick
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_P    = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] DEAD_P    = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic          DEAD_ZERO = (DEAD_CYCLES == 0);

  typedef enum logic {GAP, SCAN} state_t;

  state_t              state, n_state;
  logic [CW-1:0]       pcnt, n_pcnt;
  logic [IW-1:0]       idx, n_idx;
  logic                wrap;
  logic [3:0]          shadow [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                all_zero;
  logic                pwm_on;
  logic [NUM_DIGITS-1:0] n_an;
  logic [6:0]          n_sseg;
  logic                n_dp;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      4'hF: hex7 = 7'b0001110;
    endcase
  endfunction

`ifdef SSEG_DIM_EN
  logic [3:0] pwm_cnt;
  logic [3:0] n_pwm;

  // Free-running PWM phase; compared against brightness to gate the active anode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_cnt <= 4'd0;
    else          pwm_cnt <= n_pwm;
  end

  // Gate decision uses the phase that will be current after this edge
  always_comb begin
    n_pwm  = pwm_cnt + 4'd1;
    pwm_on = (n_pwm < brightness);
  end
`else
  // Without dimming the anode stays low for the whole SCAN phase
  always_comb pwm_on = 1'b1;
`endif

  // Shadow registers decouple the display from live digit inputs until load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) shadow[k] <= 4'd0;
      shadow_dp <= '0;
    end else if (load) begin
      for (int k = 0; k < NUM_DIGITS; k++) shadow[k] <= digits_i[4*k +: 4];
      shadow_dp <= dp_mask;
    end
  end

  // A digit is a leading zero when it and everything above it is zero; digit 0 always shows
  always_comb begin
    all_zero = 1'b1;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero    = all_zero && (shadow[k] == 4'd0);
      lz_blank[k] = blank_lz && all_zero && (k != 0);
    end
  end

  // Slot timing and GAP/SCAN sequencing for the value present after this edge
  always_comb begin
    wrap    = (pcnt == LAST_P);
    n_pcnt  = wrap ? '0 : pcnt + 1'b1;
    n_idx   = idx;
    if (wrap) n_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    n_state = state;
    case (state)
      GAP:  if (DEAD_ZERO || (n_pcnt == DEAD_P)) n_state = SCAN;
      SCAN: if (wrap && !DEAD_ZERO) n_state = GAP;
      default: n_state = GAP;
    endcase
  end

  // Output image for the next cycle, built from the settled shadow contents
  always_comb begin
    n_an   = '1;
    n_sseg = 7'h7F;
    n_dp   = 1'b1;
    if (n_state == SCAN) begin
      n_dp = ~shadow_dp[n_idx];
      if (!lz_blank[n_idx]) begin
        n_sseg = hex7(shadow[n_idx]);
        if (pwm_on) n_an[n_idx] = 1'b0;
      end
    end
  end

  // Scan state machine with registered pin outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt      <= '0;
      idx       <= '0;
      state     <= GAP;
      slot_tick <= 1'b0;
      an        <= '1;
      sseg      <= 7'h7F;
      dp        <= 1'b1;
    end else begin
      pcnt      <= n_pcnt;
      idx       <= n_idx;
      state     <= n_state;
      slot_tick <= wrap;
      an        <= n_an;
      sseg      <= n_sseg;
      dp        <= n_dp;
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb/tb_sseg_scan_mux.sv - randomized bench for sseg_scan_mux against a cycle-count reference model
module tb_sseg_scan_mux;

  localparam int ND = 4;
  localparam int PS = 8;
  localparam int DC = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] digits_i;
  logic [3:0]  dp_mask;
  logic        load;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        dp;
  logic        slot_tick;
`ifdef SSEG_DIM_EN
  logic [3:0]  brightness;
`endif

  always #5 clk = ~clk;

  sseg_scan_mux #(.NUM_DIGITS(ND), .PRESCALE(PS), .DEAD_CYCLES(DC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .digits_i  (digits_i),
    .dp_mask   (dp_mask),
    .load      (load),
    .blank_lz  (blank_lz),
`ifdef SSEG_DIM_EN
    .brightness(brightness),
`endif
    .an        (an),
    .sseg      (sseg),
    .dp        (dp),
    .slot_tick (slot_tick)
  );

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [3:0] m_dig [ND];
  logic [3:0] m_dp;
  logic [3:0] e_an;
  logic [6:0] e_sseg;
  logic       e_dp;
  logic       e_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int k = 0; k < ND; k++) m_dig[k] = 4'd0;
    m_dp = 4'd0;
  endtask

  // Expected pins after the edge just taken: slot position from elapsed cycles
  task automatic step_model();
    int  p, d;
    bit  scan, blank, lit;
    cyc++;
    p     = cyc % PS;
    d     = (cyc / PS) % ND;
    scan  = (p >= DC);
    blank = 1'b0;
    if (blank_lz && d != 0) begin
      blank = 1'b1;
      for (int k = d; k < ND; k++) if (m_dig[k] != 4'd0) blank = 1'b0;
    end
    lit = scan && !blank;
`ifdef SSEG_DIM_EN
    lit = lit && ((cyc % 16) < int'(brightness));
`endif
    e_an = 4'hF;
    if (lit) e_an[d] = 1'b0;
    e_sseg = (scan && !blank) ? seg_tab[m_dig[d]] : 7'h7F;
    e_dp   = scan ? ~m_dp[d] : 1'b1;
    e_tick = (p == 0);
    if (load) begin
      for (int k = 0; k < ND; k++) m_dig[k] = digits_i[4*k +: 4];
      m_dp = dp_mask;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      step_model();
      @(negedge clk);
      check("an", 32'(an), 32'(e_an));
      check("sseg", 32'(sseg), 32'(e_sseg));
      check("dp", 32'(dp), 32'(e_dp));
      check("slot_tick", 32'(slot_tick), 32'(e_tick));
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_an"}, 32'(an), 32'hF);
    check({tag, "_sseg"}, 32'(sseg), 32'h7F);
    check({tag, "_dp"}, 32'(dp), 32'h1);
    check({tag, "_tick"}, 32'(slot_tick), 32'h0);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int k = 0; k < ND; k++) v[4*k +: 4] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
    return v;
  endfunction

  initial begin
    int  guard;
    bit  at_d2;
    reset_n  = 1'b0;
    digits_i = 16'h0;
    dp_mask  = 4'h0;
    load     = 1'b0;
    blank_lz = 1'b0;
`ifdef SSEG_DIM_EN
    brightness = 4'd4;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_pins("reset");
    reset_n = 1'b1;

    // idle scan with zero shadow, then the 1F80 pattern
    run(34);
    digits_i = 16'h1F80; dp_mask = 4'b0010; load = 1'b1;
    run(1);
    load = 1'b0;
    run(40);

    // input changes without load stay invisible; one-cycle load pulse
    digits_i = 16'h1234;
    run(20);
    load = 1'b1;
    run(1);
    load = 1'b0;
    run(40);

    // leading-zero blanking
    blank_lz = 1'b1; digits_i = 16'h0070; dp_mask = 4'b0000; load = 1'b1;
    run(1);
    load = 1'b0;
    run(32);
    digits_i = 16'h0000; dp_mask = 4'b0100; load = 1'b1;
    run(1);
    load = 1'b0;
    run(32);
    blank_lz = 1'b0;

    // load held high: transparent update every cycle, including across wraps
    load = 1'b1;
    repeat (24) begin
      digits_i = 16'($urandom);
      dp_mask  = 4'($urandom);
      run(1);
    end
    load = 1'b0;

    // randomized traffic
    repeat (1500) begin
      if ($urandom_range(3) == 0) digits_i = rand_digits();
      dp_mask = 4'($urandom);
      load    = ($urandom_range(5) == 0);
      if ($urandom_range(47) == 0) blank_lz = ~blank_lz;
`ifdef SSEG_DIM_EN
      if ($urandom_range(99) == 0) brightness = 4'($urandom);
`endif
      run(1);
    end
    load = 1'b0;
    blank_lz = 1'b0;

`ifdef SSEG_DIM_EN
    brightness = 4'd0;
    run(40);
    brightness = 4'd4;
    run(40);
`endif

    // asynchronous reset while digit 2 is in SCAN
    digits_i = 16'hABCD; dp_mask = 4'b1111; load = 1'b1;
    run(1);
    load = 1'b0;
    guard = 0;
    at_d2 = 1'b0;
    while (!at_d2 && guard < 200) begin
      run(1);
      guard++;
      at_d2 = (((cyc / PS) % ND) == 2) && ((cyc % PS) > DC);
    end
    check("reach_digit2_scan", 32'(at_d2), 32'h1);
    #2 reset_n = 1'b0;
    #1 check_reset_pins("async_reset");
    @(negedge clk);
    check_reset_pins("held_reset");
    reset_n = 1'b1;
    model_reset();
    run(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
